uart_display_scheduler: RTL and testbench
=========================================

Name: uart_display_scheduler

Overview:
- Sits between the uart_rx byte stream (data, data_valid) and the 4-digit seven-segment driver on the Basys3.
- Parses received bytes into a 4-digit staging buffer and commits complete frames to a double-buffered display register.
- Time-multiplexes all four anodes, presenting one digit nibble at a time to the downstream seven-segment decoder.
- Flags malformed input and stalled frames.

Parameters:
- CLKS_PER_DIGIT, 100000, clk cycles each digit is lit (1 ms at 100 MHz).
- TIMEOUT_CLKS, 100000000, idle cycles after which a partial frame is discarded (1 s).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from uart_rx.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- err_clr  in  1  clears err_sticky.
- nibble  out  4  digit value for the currently scanned position.
- blank  out  1  1 = current position has no digit; segments must be off.
- an  out  4  anodes, active-low, at most one low.
- commit  out  1  one-cycle pulse when a frame is committed.
- err_sticky  out  1  set on a bad byte or timeout.
- stg_cnt  out  3  number of staged digits, 0..4.

Behaviour:
- Reset (async, rst_n=0) values:
  - staging buffer and display buffer cleared; all display valid bits 0.
  - stg_cnt=0, scan idx=0, scan and timeout counters 0.
  - nibble=0, blank=1, an=4'b1111, commit=0, err_sticky=0.
  - Reset mid-frame discards everything; no commit is emitted.
- Byte decode, acted on the cycle rx_valid=1:
  - 0x30..0x39 or 0x00..0x09 (digit d = rx_data[3:0]): shift staging left and insert d at position 0.
    - stg_cnt<4: stg_cnt++.
    - stg_cnt==4: oldest digit dropped, stg_cnt stays 4, no error.
  - 0x0D or 0x0A (commit):
    - stg_cnt>0: display[i]=staging[i] and valid[i]=(i<stg_cnt), i.e. right-aligned with leading positions blank. Staging cleared, stg_cnt=0, commit=1 on the next cycle.
    - stg_cnt==0: no-op with no pulse, so CR LF does not blank the display.
  - 0x43 or 0x63 ('C'/'c'): staging cleared, stg_cnt=0, all display valid bits 0; no commit pulse.
  - Any other byte: ignored, staging unchanged, err_sticky=1.
- Parser state: IDLE (stg_cnt==0) and COLLECT (stg_cnt>0).
  - IDLE -> COLLECT on a digit.
  - COLLECT -> IDLE on commit, clear or timeout.
- Timeout:
  - Idle counter resets on every rx_valid.
  - In COLLECT, when the counter reaches TIMEOUT_CLKS-1: staging discarded, stg_cnt=0, err_sticky=1. Display is untouched.
  - In IDLE the counter holds at 0.
- Scan:
  - Counter counts 0..CLKS_PER_DIGIT-1; on wrap, idx goes 0->1->2->3->0.
  - Outputs registered, updated the cycle after an idx or display change:
    - valid[idx]=1: an = ~(4'b0001<<idx), nibble=display[idx], blank=0.
    - valid[idx]=0: an=4'b1111, blank=1, nibble holds its previous value.
  - Position 0 is the rightmost digit.
- Simultaneous events:
  - rx_valid with timeout expiry: the byte wins. Counter reset, byte processed, no timeout error.
  - err_clr with an error-setting event: the set wins.
  - A commit landing on the same cycle as a scan wrap: the new display is shown for the new idx one cycle later.
- Width rules:
  - Only rx_data[3:0] is stored for digits.
  - stg_cnt saturates at 4.
  - Counters are sized with $clog2 of their parameter.

Test Plan:
(CLKS_PER_DIGIT=4, TIMEOUT_CLKS=50)
- Reset, then 20 cycles idle -> an=4'b1111, blank=1, commit=0, err_sticky=0 throughout.
- Bytes '1','2','3','4',0x0D -> exactly one commit pulse. Scan yields (an=1110, nibble=4), (1101,3), (1011,2), (0111,1), each held 4 cycles.
- Bytes '7','8',0x0D,0x0A -> one commit pulse only. Positions 0/1 show 8/7; positions 2/3 give an=1111, blank=1.
- Bytes '1'..'6', 0x0D -> stg_cnt saturates at 4; display shows 3,4,5,6 (pos3..pos0); err_sticky=0.
- Byte 'Z' -> err_sticky=1, stg_cnt unchanged. Then err_clr pulse -> 0. Then '5' and 50 idle cycles -> stg_cnt=0, err_sticky=1, previous display intact.
- Committed "42", then rst_n low mid-frame after '9' -> immediate an=1111, stg_cnt=0, no commit. After 'C' on a loaded display -> all positions blank within 1 cycle.

Source files
------------

// File: rtl/uart_display_scheduler.sv
// ---------------------------------------------------------------------------
// uart_display_scheduler
// Turns the uart_rx byte stream into a right-aligned 4-digit frame and scans
// it onto the Basys3 seven-segment anodes one digit at a time.
//
// Ports:
//   clk        in   system clock (100 MHz)
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   [7:0] received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   err_clr    in   clears err_sticky (an error event in the same cycle wins)
//   nibble     out  [3:0] digit value for the scanned position
//   blank      out  1 = scanned position has no digit, segments off
//   an         out  [3:0] active-low anodes, at most one low
//   commit     out  one-cycle pulse after a frame is committed
//   err_sticky out  set on an unrecognised byte or a frame timeout
//   stg_cnt    out  [2:0] number of staged digits, 0..4
// ---------------------------------------------------------------------------
module uart_display_scheduler #(
   parameter int CLKS_PER_DIGIT = 100000,
   parameter int TIMEOUT_CLKS   = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       err_clr,
   output logic [3:0] nibble,
   output logic       blank,
   output logic [3:0] an,
   output logic       commit,
   output logic       err_sticky,
   output logic [2:0] stg_cnt
);

   localparam int SW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(CLKS_PER_DIGIT - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [3:0][3:0] stg_q, stg_d;
   logic [3:0][3:0] disp_q, disp_d;
   logic [3:0]      vld_q, vld_d;
   logic [2:0]      stg_cnt_q, stg_cnt_d;
   logic [TW-1:0]   to_cnt_q, to_cnt_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      nibble_q, nibble_d;
   logic            blank_q, blank_d;
   logic [3:0]      an_q, an_d;
   logic            commit_q, commit_d;
   logic            err_q, err_d;
   logic            err_set_s;
   logic            is_digit_s, is_eol_s, is_clr_s;
   logic [3:0]      commit_mask_s;

   // Byte classification; both ASCII digits and raw 0..9 values count as digits.
   always_comb begin
      is_digit_s = ((rx_data[7:4] == 4'h3) || (rx_data[7:4] == 4'h0)) &&
                   (rx_data[3:0] <= 4'h9);
      is_eol_s   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
      is_clr_s   = (rx_data == 8'h43) || (rx_data == 8'h63);
      case (stg_cnt_q)
         3'd1:    commit_mask_s = 4'b0001;
         3'd2:    commit_mask_s = 4'b0011;
         3'd3:    commit_mask_s = 4'b0111;
         3'd4:    commit_mask_s = 4'b1111;
         default: commit_mask_s = 4'b0000;
      endcase
   end

   // Parser FSM next state: staging, display commit, timeout and error flag.
   always_comb begin
      stg_d     = stg_q;
      stg_cnt_d = stg_cnt_q;
      disp_d    = disp_q;
      vld_d     = vld_q;
      to_cnt_d  = to_cnt_q;
      commit_d  = 1'b0;
      err_set_s = 1'b0;
      if (rx_valid) begin
         // A byte always restarts the idle timer, even on the expiry cycle.
         to_cnt_d = {TW{1'b0}};
         if (is_digit_s) begin
            stg_d = {stg_q[2:0], rx_data[3:0]};
            if (stg_cnt_q < 3'd4) begin
               stg_cnt_d = stg_cnt_q + 3'd1;
            end else begin
               stg_cnt_d = 3'd4;
            end
         end else if (is_eol_s) begin
            // An empty commit is dropped so CR LF does not blank the display.
            if (stg_cnt_q != 3'd0) begin
               disp_d    = stg_q;
               vld_d     = commit_mask_s;
               stg_d     = 16'h0000;
               stg_cnt_d = 3'd0;
               commit_d  = 1'b1;
            end else begin
               commit_d  = 1'b0;
            end
         end else if (is_clr_s) begin
            stg_d     = 16'h0000;
            stg_cnt_d = 3'd0;
            vld_d     = 4'b0000;
         end else begin
            err_set_s = 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               to_cnt_d = {TW{1'b0}};
            end
            ST_COLLECT: begin
               if (to_cnt_q == TO_LAST) begin
                  stg_d     = 16'h0000;
                  stg_cnt_d = 3'd0;
                  to_cnt_d  = {TW{1'b0}};
                  err_set_s = 1'b1;
               end else begin
                  to_cnt_d  = to_cnt_q + {{(TW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               to_cnt_d = {TW{1'b0}};
            end
         endcase
      end

      if (stg_cnt_d == 3'd0) begin
         state_d = ST_IDLE;
      end else begin
         state_d = ST_COLLECT;
      end

      if (err_set_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Scan timing and registered anode/nibble/blank for the current position.
   always_comb begin
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = {SW{1'b0}};
         idx_d      = idx_q + 2'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + {{(SW-1){1'b0}}, 1'b1};
         idx_d      = idx_q;
      end
      if (vld_q[idx_q]) begin
         an_d     = ~(4'b0001 << idx_q);
         nibble_d = disp_q[idx_q];
         blank_d  = 1'b0;
      end else begin
         an_d     = 4'b1111;
         nibble_d = nibble_q;
         blank_d  = 1'b1;
      end
   end

   // State register for parser, display buffer, scanner and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         stg_q      <= 16'h0000;
         stg_cnt_q  <= 3'd0;
         disp_q     <= 16'h0000;
         vld_q      <= 4'b0000;
         to_cnt_q   <= {TW{1'b0}};
         scan_cnt_q <= {SW{1'b0}};
         idx_q      <= 2'd0;
         nibble_q   <= 4'h0;
         blank_q    <= 1'b1;
         an_q       <= 4'b1111;
         commit_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         stg_q      <= stg_d;
         stg_cnt_q  <= stg_cnt_d;
         disp_q     <= disp_d;
         vld_q      <= vld_d;
         to_cnt_q   <= to_cnt_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         nibble_q   <= nibble_d;
         blank_q    <= blank_d;
         an_q       <= an_d;
         commit_q   <= commit_d;
         err_q      <= err_d;
      end
   end

   assign nibble     = nibble_q;
   assign blank      = blank_q;
   assign an         = an_q;
   assign commit     = commit_q;
   assign err_sticky = err_q;
   assign stg_cnt    = stg_cnt_q;

endmodule

// File: tb/tb_uart_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_display_scheduler
// Directed bench for uart_display_scheduler with CLKS_PER_DIGIT=4 and
// TIMEOUT_CLKS=50. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge or 1 ns after a rising edge.
// ---------------------------------------------------------------------------
module tb_uart_display_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] nibble;
   logic       blank;
   logic [3:0] an;
   logic       commit;
   logic       err_sticky;
   logic [2:0] stg_cnt;

   int checks = 0;
   int errors = 0;
   int commit_cnt = 0;
   int base;

   uart_display_scheduler #(
      .CLKS_PER_DIGIT(4),
      .TIMEOUT_CLKS  (50)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .err_clr   (err_clr),
      .nibble    (nibble),
      .blank     (blank),
      .an        (an),
      .commit    (commit),
      .err_sticky(err_sticky),
      .stg_cnt   (stg_cnt)
   );

   always #5 clk = ~clk;

   // Counts commit pulses, one per high cycle.
   always @(negedge clk) begin
      if (commit) commit_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Align to the first cycle of position 0 being lit.
   task automatic sync_pos0();
      int n;
      n = 0;
      @(negedge clk);
      while (an == 4'b1110 && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (an != 4'b1110 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("sync_pos0_an", 16'(an), 16'h000E);
   endtask

   // Check one full scan round: 4 positions, each held 4 cycles.
   task automatic check_scan(input logic [15:0] nibs, input logic [3:0] vmask);
      logic [3:0] exp_an;
      logic [3:0] held;
      int q;
      sync_pos0();
      for (int p = 0; p < 4; p++) begin
         exp_an = 4'b1111;
         held   = 4'h0;
         if (vmask[p]) begin
            exp_an[p] = 1'b0;
         end
         for (int k = 1; k < 4; k++) begin
            q = (p + 4 - k) % 4;
            if (vmask[q]) begin
               held = nibs[q*4 +: 4];
               break;
            end
         end
         for (int c = 0; c < 4; c++) begin
            if (!(p == 0 && c == 0)) @(negedge clk);
            chk($sformatf("scan_an_p%0d_c%0d", p, c), 16'(an), 16'(exp_an));
            chk($sformatf("scan_blank_p%0d_c%0d", p, c), 16'(blank), 16'(!vmask[p]));
            if (vmask[p]) begin
               chk($sformatf("scan_nib_p%0d_c%0d", p, c), 16'(nibble), 16'(nibs[p*4 +: 4]));
            end else begin
               chk($sformatf("scan_hold_p%0d_c%0d", p, c), 16'(nibble), 16'(held));
            end
         end
      end
   endtask

   initial begin
      // Reset and idle.
      #12;
      chk("rst_an", 16'(an), 16'h000F);
      chk("rst_blank", 16'(blank), 16'h0001);
      chk("rst_nibble", 16'(nibble), 16'h0000);
      chk("rst_stg_cnt", 16'(stg_cnt), 16'h0000);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_an", 16'(an), 16'h000F);
         chk("idle_blank", 16'(blank), 16'h0001);
         chk("idle_commit", 16'(commit), 16'h0000);
         chk("idle_err", 16'(err_sticky), 16'h0000);
      end

      // Full frame "1234".
      base = commit_cnt;
      send_byte(8'h31);
      send_byte(8'h32);
      send_byte(8'h33);
      send_byte(8'h34);
      chk("f1_stg_cnt", 16'(stg_cnt), 16'h0004);
      send_byte(8'h0D);
      chk("f1_commit_pulse", 16'(commit), 16'h0001);
      chk("f1_stg_clr", 16'(stg_cnt), 16'h0000);
      cycles(3);
      chk("f1_commit_cnt", 16'(commit_cnt - base), 16'h0001);
      check_scan(16'h1234, 4'b1111);

      // Partial frame "78" followed by CR LF.
      base = commit_cnt;
      send_byte(8'h37);
      send_byte(8'h38);
      send_byte(8'h0D);
      send_byte(8'h0A);
      cycles(3);
      chk("f2_commit_cnt", 16'(commit_cnt - base), 16'h0001);
      check_scan(16'h0078, 4'b0011);

      // Saturation with "123456".
      for (int i = 1; i <= 6; i++) begin
         send_byte(8'(8'h30 + i));
      end
      chk("f3_stg_sat", 16'(stg_cnt), 16'h0004);
      send_byte(8'h0D);
      chk("f3_err", 16'(err_sticky), 16'h0000);
      check_scan(16'h3456, 4'b1111);

      // Bad byte, error clear, then timeout of a partial frame.
      send_byte(8'h39);
      send_byte(8'h5A);
      chk("bad_err", 16'(err_sticky), 16'h0001);
      chk("bad_stg_cnt", 16'(stg_cnt), 16'h0001);
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      chk("errclr", 16'(err_sticky), 16'h0000);
      send_byte(8'h35);
      chk("to_stg_cnt2", 16'(stg_cnt), 16'h0002);
      cycles(45);
      chk("to_not_yet_cnt", 16'(stg_cnt), 16'h0002);
      chk("to_not_yet_err", 16'(err_sticky), 16'h0000);
      cycles(5);
      chk("to_stg_cnt0", 16'(stg_cnt), 16'h0000);
      chk("to_err", 16'(err_sticky), 16'h0001);
      check_scan(16'h3456, 4'b1111);

      // Commit "42", then reset in the middle of a new frame.
      send_byte(8'h34);
      send_byte(8'h32);
      send_byte(8'h0D);
      send_byte(8'h39);
      base = commit_cnt;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_an", 16'(an), 16'h000F);
      chk("mrst_stg_cnt", 16'(stg_cnt), 16'h0000);
      chk("mrst_err", 16'(err_sticky), 16'h0000);
      cycles(2);
      rst_n = 1'b1;
      cycles(10);
      chk("mrst_no_commit", 16'(commit_cnt - base), 16'h0000);
      chk("mrst_an_idle", 16'(an), 16'h000F);

      // Raw-value digits, then 'C' clears the loaded display.
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h0A);
      check_scan(16'h0012, 4'b0011);
      base = commit_cnt;
      send_byte(8'h43);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         chk("clr_an", 16'(an), 16'h000F);
         chk("clr_blank", 16'(blank), 16'h0001);
         @(negedge clk);
      end
      chk("clr_no_commit", 16'(commit_cnt - base), 16'h0000);
      chk("clr_err", 16'(err_sticky), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
